// File: rtl/sc_bitstream_acc_if.sv
// Handshake and result bundle between a conversion controller and sc_bitstream_acc.
interface sc_bitstream_acc_if #(
  parameter int CWIDTH = 8
);
  logic              start;
  logic              abort;
  logic              in;
  logic              busy;
  logic              valid;
  logic [CWIDTH:0]   result;

  // Controller side: requests conversions, feeds the bitstream, reads the count.
  modport master (
    output start, abort, in,
    input  busy, valid, result
  );

  // Accumulator side.
  modport slave (
    input  start, abort, in,
    output busy, valid, result
  );
endinterface

// File: rtl/sc_bitstream_acc.sv
// Stochastic bitstream to binary converter: optional warm-up discard, then
// counts ones over a window of 2^CWIDTH samples and reports the count.
module sc_bitstream_acc #(
  parameter int CWIDTH = 8,
  parameter int WARMUP = 16,
  parameter int WWIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  sc_bitstream_acc_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WARM = 2'd1,
    S_ACC  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam bit                HAS_WARM  = (WARMUP > 0);
  localparam logic [WWIDTH-1:0] WARM_LAST = WWIDTH'((WARMUP > 0) ? (WARMUP - 1) : 0);
  localparam logic [CWIDTH-1:0] WIN_LAST  = {CWIDTH{1'b1}};

  state_t            state_q, state_d;
  logic [WWIDTH-1:0] warm_q, warm_d;
  logic [CWIDTH-1:0] win_q, win_d;
  logic [CWIDTH:0]   ones_q, ones_d;
  logic [CWIDTH:0]   result_q, result_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;
  logic [CWIDTH:0]   in_ext;

  // Current sample zero-extended to the ones-counter width.
  assign in_ext = {{CWIDTH{1'b0}}, bus.in};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; abort takes priority over start and over window completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start && !bus.abort) begin
          state_d = HAS_WARM ? S_WARM : S_ACC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WARM: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (warm_q == WARM_LAST) begin
          state_d = S_ACC;
        end else begin
          state_d = S_WARM;
        end
      end
      S_ACC: begin
        if (bus.abort) begin
          state_d = S_IDLE;
        end else if (win_q == WIN_LAST) begin
          state_d = S_DONE;
        end else begin
          state_d = S_ACC;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Counter, result and status updates; counters read as zero outside their own phase,
  // so any entry into WARM or ACC starts from a cleared count.
  always_comb begin
    warm_d   = {WWIDTH{1'b0}};
    win_d    = {CWIDTH{1'b0}};
    ones_d   = {(CWIDTH+1){1'b0}};
    result_d = result_q;
    busy_d   = (state_d == S_WARM) || (state_d == S_ACC);
    valid_d  = (state_d == S_DONE);
    case (state_q)
      S_WARM: begin
        if (state_d == S_WARM) begin
          warm_d = warm_q + WWIDTH'(1'b1);
        end else begin
          warm_d = {WWIDTH{1'b0}};
        end
      end
      S_ACC: begin
        if (state_d == S_ACC) begin
          win_d  = win_q + CWIDTH'(1'b1);
          ones_d = ones_q + in_ext;
        end else if (state_d == S_DONE) begin
          // Final sample of the window is part of the result.
          result_d = ones_q + in_ext;
        end else begin
          result_d = result_q;
        end
      end
      default: begin
        result_d = result_q;
      end
    endcase
  end

  // Datapath and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm_q   <= {WWIDTH{1'b0}};
      win_q    <= {CWIDTH{1'b0}};
      ones_q   <= {(CWIDTH+1){1'b0}};
      result_q <= {(CWIDTH+1){1'b0}};
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      warm_q   <= warm_d;
      win_q    <= win_d;
      ones_q   <= ones_d;
      result_q <= result_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.busy   = busy_q;
  assign bus.valid  = valid_q;
  assign bus.result = result_q;

endmodule

// File: tb/tb_sc_bitstream_acc.sv
// Scoreboard bench for sc_bitstream_acc: a default instance (CWIDTH=8, WARMUP=16)
// and a short instance (CWIDTH=4, WARMUP=0), exercised one after the other.
module tb_sc_bitstream_acc;

  typedef struct {
    int res;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_errors;
  int   valid_cnt[2];
  int   exp_last[2];
  exp_t q_a[$];
  exp_t q_b[$];

  sc_bitstream_acc_if #(.CWIDTH(8)) if_a ();
  sc_bitstream_acc_if #(.CWIDTH(4)) if_b ();

  sc_bitstream_acc #(.CWIDTH(8), .WARMUP(16), .WWIDTH(8)) dut_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_a.slave)
  );

  sc_bitstream_acc #(.CWIDTH(4), .WARMUP(0), .WWIDTH(8)) dut_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to time-stamp expected completions.
  always @(posedge clk) cyc = cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic s, input logic a, input logic b);
    if (sel == 0) begin
      if_a.start = s; if_a.abort = a; if_a.in = b;
    end else begin
      if_b.start = s; if_b.abort = a; if_b.in = b;
    end
  endtask

  function automatic int get_busy(input int sel);
    return (sel == 0) ? int'(if_a.busy) : int'(if_b.busy);
  endfunction

  function automatic int get_valid(input int sel);
    return (sel == 0) ? int'(if_a.valid) : int'(if_b.valid);
  endfunction

  function automatic int get_result(input int sel);
    return (sel == 0) ? int'(if_a.result) : int'(if_b.result);
  endfunction

  // Result monitor for the default instance.
  always @(negedge clk) begin
    if (rst_n && if_a.valid) begin
      exp_t e;
      valid_cnt[0]++;
      if (q_a.size() == 0) begin
        check_eq("a_unexpected_valid", 1, 0);
      end else begin
        e = q_a.pop_front();
        check_eq("a_result", int'(if_a.result), e.res);
        check_eq("a_latency", cyc, e.cyc);
        exp_last[0] = e.res;
      end
    end
  end

  // Result monitor for the short instance.
  always @(negedge clk) begin
    if (rst_n && if_b.valid) begin
      exp_t e;
      valid_cnt[1]++;
      if (q_b.size() == 0) begin
        check_eq("b_unexpected_valid", 1, 0);
      end else begin
        e = q_b.pop_front();
        check_eq("b_result", int'(if_b.result), e.res);
        check_eq("b_latency", cyc, e.cyc);
        exp_last[1] = e.res;
      end
    end
  end

  // One full conversion. mode: 0 zeros, 1 ones, 2 alternating, 3 random, 4 five ones.
  // Warm-up bits are driven high and must be ignored.
  task automatic run_conv(input int sel, input int mode, input bit start_mid, input bit start_done);
    int   w;
    int   n;
    int   ones;
    logic pat[256];
    exp_t e;
    w = (sel == 0) ? 16 : 0;
    n = (sel == 0) ? 256 : 16;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      case (mode)
        0:       pat[i] = 1'b0;
        1:       pat[i] = 1'b1;
        2:       pat[i] = ((i % 2) == 0);
        3:       pat[i] = 1'($urandom_range(0, 1));
        default: pat[i] = (i < 5);
      endcase
      ones += int'(pat[i]);
    end
    @(negedge clk);
    drive(sel, 1'b1, 1'b0, 1'b1);
    e.res = ones;
    e.cyc = cyc + 1 + w + n;
    if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
    for (int j = 0; j < w; j++) begin
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, 1'b1);
    end
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (i == 0)     check_eq("busy_start", get_busy(sel), 1);
      if (i == n / 2) check_eq("result_hold", get_result(sel), exp_last[sel]);
      if (i == n - 1) check_eq("busy_last", get_busy(sel), 1);
      drive(sel, start_mid && (i == n / 2), 1'b0, pat[i]);
    end
    @(negedge clk);
    check_eq("valid_done", get_valid(sel), 1);
    check_eq("busy_done", get_busy(sel), 0);
    drive(sel, start_done, 1'b0, 1'b0);
    @(negedge clk);
    drive(sel, 1'b0, 1'b0, 1'b0);
    check_eq("valid_pulse_end", get_valid(sel), 0);
    check_eq("busy_after_done", get_busy(sel), 0);
    repeat (3) @(negedge clk);
    check_eq("busy_idle", get_busy(sel), 0);
  endtask

  initial begin
    cyc = 0;
    n_checks = 0;
    n_errors = 0;
    valid_cnt[0] = 0; valid_cnt[1] = 0;
    exp_last[0] = 0;  exp_last[1] = 0;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 1'b0);
    drive(1, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_eq("rst_busy", int'(if_a.busy), 0);
    check_eq("rst_valid", int'(if_a.valid), 0);
    check_eq("rst_result", int'(if_a.result), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Default instance: all ones with ignored start pulses, zeros, alternating, random.
    run_conv(0, 1, 1'b1, 1'b1);
    run_conv(0, 0, 1'b0, 1'b0);
    run_conv(0, 2, 1'b0, 1'b0);
    run_conv(0, 3, 1'b0, 1'b0);
    run_conv(0, 1, 1'b0, 1'b0);

    // Abort 100 samples into the window.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b1);
    repeat (16 + 100) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b1);
    end
    check_eq("abort_busy_before", int'(if_a.busy), 1);
    drive(0, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0);
    check_eq("abort_busy", int'(if_a.busy), 0);
    check_eq("abort_valid", int'(if_a.valid), 0);
    repeat (300) @(negedge clk);
    check_eq("abort_result_kept", int'(if_a.result), exp_last[0]);

    // Start and abort together in IDLE: abort wins.
    drive(0, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0);
    check_eq("start_abort_idle", int'(if_a.busy), 0);
    repeat (3) @(negedge clk);

    // Normal conversion after abort.
    run_conv(0, 2, 1'b0, 1'b0);

    // Short instance, no warm-up: five ones, then a full window with result held meanwhile.
    run_conv(1, 4, 1'b0, 1'b0);
    run_conv(1, 1, 1'b0, 1'b0);
    check_eq("b_last_result", int'(if_b.result), 16);

    // Asynchronous reset in the middle of the window.
    @(negedge clk);
    drive(0, 1'b1, 1'b0, 1'b1);
    repeat (16 + 50) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b0, 1'b1);
    end
    check_eq("pre_reset_result", int'(if_a.result), exp_last[0]);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("arst_busy", int'(if_a.busy), 0);
    check_eq("arst_valid", int'(if_a.valid), 0);
    check_eq("arst_result", int'(if_a.result), 0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);
    check_eq("post_reset_busy", int'(if_a.busy), 0);

    check_eq("a_valid_count", valid_cnt[0], 6);
    check_eq("b_valid_count", valid_cnt[1], 2);
    check_eq("a_pending", q_a.size(), 0);
    check_eq("b_pending", q_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sc_bitstream_acc.md
Name: sc_bitstream_acc

Overview:
- Downstream stage of the stochastic square-root unit.
- Converts a unipolar stochastic bitstream (for example, the sqrt unit's output) back to binary by counting ones over a fixed window of 2^CWIDTH cycles.
- Optionally discards an initial warm-up period first, so the upstream unit's internal counter can settle before measurement.
- Driven by a start/valid handshake from the test or datapath controller.

Parameters:
- CWIDTH, 8: log2 of the accumulation window length. Window = 2^CWIDTH cycles.
- WARMUP, 16: number of cycles whose input bits are discarded before accumulation starts. 0 skips the warm-up phase entirely.
- WWIDTH, 8: width of the warm-up counter. Requires WARMUP <= 2^WWIDTH - 1.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous reset, active low
- start  input  1  request one conversion; honoured only in IDLE
- abort  input  1  synchronous cancel of the conversion in progress
- in  input  1  stochastic bitstream, sampled every rising edge
- busy  output  1  high while in WARM or ACC
- valid  output  1  one-cycle pulse; result is fresh
- result  output  CWIDTH+1  number of ones seen in the last completed window, range 0..2^CWIDTH

Behaviour:
- Interface: one clock, clk. Reset is asynchronous and active-low, on rst_n.
- States are IDLE, WARM, ACC and DONE. Reset enters IDLE.
- Reset values:
  - busy=0, valid=0, result=0.
  - Warm-up counter=0, window counter=0, ones counter=0.
- IDLE:
  - If start=1 at an edge and WARMUP>0: go to WARM, warm counter cleared.
  - If start=1 at an edge and WARMUP=0: go directly to ACC.
  - Entering ACC always clears the window counter and ones counter.
  - If start=0: stay in IDLE.
- WARM:
  - in is ignored.
  - The warm counter increments every edge.
  - On the edge where warm counter == WARMUP-1, go to ACC. WARM therefore lasts exactly WARMUP cycles.
- ACC:
  - At each edge, ones counter += in, and the window counter increments (CWIDTH bits).
  - On the edge where the window counter == 2^CWIDTH-1:
    - The final sample is included.
    - result <= ones + in.
    - Go to DONE.
  - ACC lasts exactly 2^CWIDTH cycles. The window counter wraps to 0.
- DONE: valid=1 for exactly one cycle, then unconditionally IDLE. start in the DONE cycle is ignored.
- Latency: valid is high in the cycle after the edge at WARMUP + 2^CWIDTH edges following the edge that sampled start.
- result holds its value from completion until the next completion. It is not cleared by start or abort.
- abort:
  - Sampled at every edge. In WARM or ACC it forces IDLE on that edge.
  - No valid pulse; result unchanged; counters cleared.
  - abort in IDLE or DONE has no effect.
  - abort and start together in IDLE: abort wins; stay in IDLE.
- start while busy is ignored; it is not queued.
- Width rule: the ones counter is CWIDTH+1 bits, so an all-ones window yields exactly 2^CWIDTH with no overflow or saturation.
- busy = (state==WARM) | (state==ACC). Both busy and valid are decoded from registered state, so there is no combinational path from the inputs.
- Reset asserted mid-conversion returns to IDLE immediately: all counters 0, result 0, valid 0.

Test Plan:
- Defaults, in held at 1, start pulsed at edge k:
  - busy=1 from k+1 through edge k+272.
  - valid=1 for one cycle after edge k+272.
  - result=256.
- Defaults, in held at 0 → valid after 272 edges, result=0.
- Defaults, in = alternating 1,0 starting at the first ACC sample → result=128. Bits driven high during WARM (16 cycles of 1) must not contribute.
- WARMUP=0, CWIDTH=4, in = 1 for 5 cycles then 0 → valid after 16 edges, result=5. Then a second start with all ones → result=16, and result holds 5 until that second valid.
- Defaults, abort asserted 100 cycles into ACC:
  - IDLE on the next edge, busy=0, no valid.
  - result keeps its prior value (e.g. 256).
  - A new start then produces a normal result.
- rst_n dropped to 0 mid-ACC, asynchronously:
  - busy, valid and result go to 0 immediately.
  - start pulses during a conversion and in the DONE cycle are ignored (valid count = 1 per accepted start).
